// File: rtl/rx_storage_fifo_pkg.sv
// rtl/rx_storage_fifo_pkg.sv - shared CAN frame layout and rx store defaults
package rx_storage_fifo_pkg;

  localparam int CAN_FRAME_W  = 128;
  localparam int CAN_RX_DEPTH = 4;

  // Packed frame layout, identical to the Tx storage format
  typedef struct packed {
    logic [63:0] data;
    logic [28:0] rsvd_hi;
    logic        ide;
    logic        rtr;
    logic [3:0]  dlc;
    logic [28:0] id;
  } can_frame_t;

  localparam int FRM_ID_LSB   = 0;
  localparam int FRM_ID_W     = 29;
  localparam int FRM_DLC_LSB  = 29;
  localparam int FRM_DLC_W    = 4;
  localparam int FRM_DATA_LSB = 64;
  localparam int FRM_DATA_W   = 64;

  function automatic int rx_cnt_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/rx_storage_fifo_if.sv
// rtl/rx_storage_fifo_if.sv - receiver/host side signals of the rx frame store
interface rx_storage_fifo_if
  import rx_storage_fifo_pkg::*;
#(
  parameter int FRAME_W = CAN_FRAME_W,
  parameter int CNT_W   = rx_cnt_w(CAN_RX_DEPTH)
);
  logic               store_data;
  logic [FRAME_W-1:0] rxbuf_ip;
  logic               release_rb;
  logic               clr_overrun;
  logic [FRAME_W-1:0] rxbuf_op;
  logic               RBS;
  logic               DOS;
  logic               RBFULL;
  logic [CNT_W-1:0]   rx_msg_count;
  logic               rx_int;

  modport master (
    output store_data, rxbuf_ip, release_rb, clr_overrun,
    input  rxbuf_op, RBS, DOS, RBFULL, rx_msg_count, rx_int
  );

  modport slave (
    input  store_data, rxbuf_ip, release_rb, clr_overrun,
    output rxbuf_op, RBS, DOS, RBFULL, rx_msg_count, rx_int
  );
endinterface

// File: rtl/rx_storage_fifo_ram.sv
// rtl/rx_storage_fifo_ram.sv - frame array with sync write and async indexed read
module rx_storage_fifo_ram #(
  parameter int FRAME_W = 128,
  parameter int DEPTH   = 4,
  parameter int PTR_W   = $clog2(DEPTH)
) (
  input  logic               clk,
  input  logic               we,
  input  logic [PTR_W-1:0]   waddr,
  input  logic [FRAME_W-1:0] wdata,
  input  logic [PTR_W-1:0]   raddr,
  output logic [FRAME_W-1:0] rdata
);

  logic [FRAME_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/rx_storage_fifo.sv
// rtl/rx_storage_fifo.sv - receive frame FIFO with status, sticky overrun and rx interrupt
module rx_storage_fifo
  import rx_storage_fifo_pkg::*;
#(
  parameter int FRAME_W = CAN_FRAME_W,
  parameter int DEPTH   = CAN_RX_DEPTH,
  parameter int CNT_W   = rx_cnt_w(DEPTH)
) (
  input  logic              sys_clk,
  input  logic              sys_rst,
  rx_storage_fifo_if.slave  bus
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [PTR_W-1:0]   wr_ptr, rd_ptr, rd_ptr_next;
  logic [CNT_W-1:0]   count, count_next;
  logic               rel_ok, st_ok, overrun;
  logic [FRAME_W-1:0] head_ram, head_next, head_q;
  logic               rbs_q, dos_q, rbfull_q, int_q;

  assign rel_ok  = bus.release_rb && (count != '0);
  // A release frees the slot a full-FIFO store needs in the same cycle
  assign st_ok   = bus.store_data && ((count != CNT_W'(DEPTH)) || rel_ok);
  assign overrun = bus.store_data && !st_ok;

  assign rd_ptr_next = rd_ptr + PTR_W'(rel_ok);

  always_comb begin
    count_next = count;
    case ({st_ok, rel_ok})
      2'b10:   count_next = count + CNT_W'(1);
      2'b01:   count_next = count - CNT_W'(1);
      default: count_next = count;
    endcase
  end

  // The frame being written this edge is not in the array yet; bypass it
  assign head_next = (st_ok && (wr_ptr == rd_ptr_next)) ? bus.rxbuf_ip : head_ram;

  rx_storage_fifo_ram #(
    .FRAME_W (FRAME_W),
    .DEPTH   (DEPTH),
    .PTR_W   (PTR_W)
  ) u_ram (
    .clk   (sys_clk),
    .we    (st_ok),
    .waddr (wr_ptr),
    .wdata (bus.rxbuf_ip),
    .raddr (rd_ptr_next),
    .rdata (head_ram)
  );

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      head_q   <= '0;
      rbs_q    <= 1'b0;
      dos_q    <= 1'b0;
      rbfull_q <= 1'b0;
      int_q    <= 1'b0;
    end else begin
      wr_ptr   <= wr_ptr + PTR_W'(st_ok);
      rd_ptr   <= rd_ptr_next;
      count    <= count_next;
      rbs_q    <= (count_next != '0);
      rbfull_q <= (count_next == CNT_W'(DEPTH));
      int_q    <= st_ok;
      dos_q    <= overrun || (dos_q && !bus.clr_overrun);
      if (count_next != '0) begin
        head_q <= head_next;
      end
    end
  end

  assign bus.rxbuf_op     = head_q;
  assign bus.RBS          = rbs_q;
  assign bus.DOS          = dos_q;
  assign bus.RBFULL       = rbfull_q;
  assign bus.rx_msg_count = count;
  assign bus.rx_int       = int_q;

endmodule
